// File: rtl/cpu_execute_pkg.sv
// Shared types for the execute stage: pipeline tag width, operation codes and FSM states.
// Operation codes 29..31 are unused and produce a zero result.
package cpu_execute_pkg;

    localparam int TAG_SIZE = 8;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_LUI    = 5'd10,
        OP_BEQ    = 5'd11,
        OP_BNE    = 5'd12,
        OP_BLT    = 5'd13,
        OP_BGE    = 5'd14,
        OP_BLTU   = 5'd15,
        OP_BGEU   = 5'd16,
        OP_JAL    = 5'd17,
        OP_JALR   = 5'd18,
        OP_LOAD   = 5'd19,
        OP_STORE  = 5'd20,
        OP_MUL    = 5'd21,
        OP_MULH   = 5'd22,
        OP_MULHSU = 5'd23,
        OP_MULHU  = 5'd24,
        OP_DIV    = 5'd25,
        OP_DIVU   = 5'd26,
        OP_REM    = 5'd27,
        OP_REMU   = 5'd28
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MULDIV = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    function automatic logic is_muldiv(input op_e op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/cpu_muldiv.sv
// Iterative unsigned multiplier / restoring divider, one result bit per step, STEPS steps after start.
// No backpressure: done_o pulses on the last step and res_o is valid only in that cycle.
module cpu_muldiv
    import cpu_execute_pkg::*;
#(
    parameter int STEPS = 32
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        div_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        done_o,
    output logic [63:0] res_o
);

    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

    // acc_q holds {partial product} for multiply and {remainder, quotient} for divide.
    logic [63:0]   acc_q, acc_d, step_res;
    logic [31:0]   b_q, b_d;
    logic          div_q, div_d, run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [32:0]   mul_sum, div_rs;
    logic [33:0]   div_diff;

    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
        div_rs   = {acc_q[63:32], acc_q[31]};
        div_diff = {1'b0, div_rs} - {2'b00, b_q};
        if (div_q) begin
            step_res = div_diff[33] ? {div_rs[31:0], acc_q[30:0], 1'b0}
                                    : {div_diff[31:0], acc_q[30:0], 1'b1};
        end else begin
            step_res = {mul_sum, acc_q[31:1]};
        end
    end

    assign done_o = run_q && (cnt_q == CW'(STEPS - 1));
    assign res_o  = step_res;

    always_comb begin
        acc_d = acc_q;
        b_d   = b_q;
        div_d = div_q;
        run_d = run_q;
        cnt_d = cnt_q;
        if (start_i && !run_q) begin
            acc_d = {32'd0, a_i};
            b_d   = b_i;
            div_d = div_i;
            run_d = 1'b1;
            cnt_d = '0;
        end else if (run_q) begin
            acc_d = step_res;
            cnt_d = cnt_q + 1'b1;
            if (done_o) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
            div_q <= div_d;
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_execute.sv
// Execute stage: ALU/branch/address ops retire in 1 edge, RV32M ops in 1+MD_STEPS edges.
// Holds outputs while i_stall is high; o_busy stalls decode while an instruction cannot retire.
module cpu_execute
    import cpu_execute_pkg::*;
#(
    parameter int TAG_W    = TAG_SIZE,
    parameter int MD_STEPS = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [TAG_W-1:0] i_tag,
    input  logic [31:0]      i_pc,
    input  logic [4:0]       i_inst_rd,
    input  logic [31:0]      i_rs1,
    input  logic [31:0]      i_rs2,
    input  logic [31:0]      i_imm,
    input  logic [4:0]       i_op,
    input  logic             i_src2_imm,
    input  logic             i_mem_read,
    input  logic             i_mem_write,
    input  logic [2:0]       i_mem_width,
    input  logic             i_mem_signed,
    input  logic             i_stall,
    output logic [TAG_W-1:0] o_tag,
    output logic [4:0]       o_inst_rd,
    output logic [31:0]      o_rd,
    output logic [31:0]      o_pc_next,
    output logic             o_branch,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic [2:0]       o_mem_width,
    output logic             o_mem_signed,
    output logic [31:0]      o_mem_address,
    output logic             o_busy
);

    op_e         op;
    logic [31:0] op2, pc_plus4, pc_imm, mem_addr;
    logic [31:0] alu_rd, alu_pc;
    logic        alu_br, taken;

    assign op       = op_e'(i_op);
    assign op2      = i_src2_imm ? i_imm : i_rs2;
    assign pc_plus4 = i_pc + 32'd4;
    assign pc_imm   = i_pc + i_imm;
    assign mem_addr = i_rs1 + i_imm;

    always_comb begin
        alu_rd = '0;
        alu_pc = pc_plus4;
        alu_br = 1'b0;
        taken  = 1'b0;
        case (op)
            OP_ADD:   alu_rd = i_rs1 + op2;
            OP_SUB:   alu_rd = i_rs1 - op2;
            OP_SLL:   alu_rd = i_rs1 << op2[4:0];
            OP_SLT:   alu_rd = {31'd0, $signed(i_rs1) < $signed(op2)};
            OP_SLTU:  alu_rd = {31'd0, i_rs1 < op2};
            OP_XOR:   alu_rd = i_rs1 ^ op2;
            OP_SRL:   alu_rd = i_rs1 >> op2[4:0];
            OP_SRA:   alu_rd = $signed(i_rs1) >>> op2[4:0];
            OP_OR:    alu_rd = i_rs1 | op2;
            OP_AND:   alu_rd = i_rs1 & op2;
            OP_LUI:   alu_rd = op2;
            // Branch conditions always compare the two register operands.
            OP_BEQ:   taken = (i_rs1 == i_rs2);
            OP_BNE:   taken = (i_rs1 != i_rs2);
            OP_BLT:   taken = ($signed(i_rs1) < $signed(i_rs2));
            OP_BGE:   taken = ($signed(i_rs1) >= $signed(i_rs2));
            OP_BLTU:  taken = (i_rs1 < i_rs2);
            OP_BGEU:  taken = (i_rs1 >= i_rs2);
            OP_JAL: begin
                alu_rd = pc_plus4;
                alu_pc = pc_imm;
                alu_br = 1'b1;
            end
            OP_JALR: begin
                alu_rd = pc_plus4;
                alu_pc = mem_addr & ~32'd1;
                alu_br = 1'b1;
            end
            OP_LOAD, OP_STORE: alu_rd = i_rs2;
            default:  alu_rd = '0;
        endcase
        if (taken) begin
            alu_pc = pc_imm;
            alu_br = 1'b1;
        end
    end

    // The iterative unit sees magnitudes only; signs and corner cases are resolved here.
    logic        md_op, md_div, a_sgn, b_sgn, a_neg, b_neg, md_ovf;
    logic [31:0] mag_a, mag_b;
    logic        md_start, md_done;
    logic [63:0] md_raw, prod_s;
    logic [31:0] quo_s, rem_s, md_res;

    assign md_op  = is_muldiv(op);
    assign md_div = md_op && (op >= OP_DIV);
    assign a_sgn  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign b_sgn  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign a_neg  = a_sgn && i_rs1[31];
    assign b_neg  = b_sgn && op2[31];
    assign mag_a  = a_neg ? (32'd0 - i_rs1) : i_rs1;
    assign mag_b  = b_neg ? (32'd0 - op2) : op2;
    assign md_ovf = md_div && b_sgn && (i_rs1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);

    op_e         mop_q;
    logic        qneg_q, rneg_q, dz_q, ovf_q;
    logic [31:0] dvd_q, hold_q;

    cpu_muldiv #(
        .STEPS (MD_STEPS)
    ) u_muldiv (
        .clk_i   (i_clock),
        .rst_n_i (i_reset),
        .start_i (md_start),
        .div_i   (md_div),
        .a_i     (mag_a),
        .b_i     (mag_b),
        .done_o  (md_done),
        .res_o   (md_raw)
    );

    always_comb begin
        md_res = '0;
        prod_s = qneg_q ? (64'd0 - md_raw) : md_raw;
        quo_s  = qneg_q ? (32'd0 - md_raw[31:0]) : md_raw[31:0];
        rem_s  = rneg_q ? (32'd0 - md_raw[63:32]) : md_raw[63:32];
        case (mop_q)
            OP_MUL:                       md_res = prod_s[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: md_res = prod_s[63:32];
            OP_DIV, OP_DIVU:              md_res = dz_q ? 32'hFFFF_FFFF : (ovf_q ? 32'h8000_0000 : quo_s);
            OP_REM, OP_REMU:              md_res = dz_q ? dvd_q : (ovf_q ? 32'd0 : rem_s);
            default:                      md_res = '0;
        endcase
    end

    state_e             state_q, state_d;
    logic [TAG_W-1:0]   tag_q;
    logic [4:0]         rd_idx_q;
    logic [31:0]        rd_q, pcn_q, maddr_q, rd_d, pcn_d;
    logic               br_q, br_d, mr_q, mw_q, msg_q;
    logic [2:0]         mwid_q;
    logic               new_inst, accept, wr_en, hold_en;

    assign new_inst = (i_tag != tag_q);
    assign accept   = (state_q == ST_IDLE) && new_inst && !i_stall;

    always_comb begin
        state_d  = state_q;
        wr_en    = 1'b0;
        md_start = 1'b0;
        hold_en  = 1'b0;
        rd_d     = alu_rd;
        pcn_d    = alu_pc;
        br_d     = alu_br;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (md_op) begin
                        md_start = 1'b1;
                        state_d  = ST_MULDIV;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            ST_MULDIV: begin
                rd_d  = md_res;
                pcn_d = pc_plus4;
                br_d  = 1'b0;
                if (md_done) begin
                    if (i_stall) begin
                        hold_en = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        wr_en   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                rd_d  = hold_q;
                pcn_d = pc_plus4;
                br_d  = 1'b0;
                if (!i_stall) begin
                    wr_en   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            mop_q    <= OP_ADD;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            dvd_q    <= '0;
            hold_q   <= '0;
            tag_q    <= '0;
            rd_idx_q <= '0;
            rd_q     <= '0;
            pcn_q    <= '0;
            br_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            mwid_q   <= '0;
            msg_q    <= 1'b0;
            maddr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (md_start) begin
                mop_q  <= op;
                qneg_q <= a_neg ^ b_neg;
                rneg_q <= a_neg;
                dz_q   <= (op2 == 32'd0);
                ovf_q  <= md_ovf;
                dvd_q  <= i_rs1;
            end
            if (hold_en) begin
                hold_q <= md_res;
            end
            if (wr_en) begin
                tag_q    <= i_tag;
                rd_idx_q <= i_inst_rd;
                rd_q     <= rd_d;
                pcn_q    <= pcn_d;
                br_q     <= br_d;
                mr_q     <= i_mem_read;
                mw_q     <= i_mem_write;
                mwid_q   <= i_mem_width;
                msg_q    <= i_mem_signed;
                maddr_q  <= mem_addr;
            end
        end
    end

    assign o_tag         = tag_q;
    assign o_inst_rd     = rd_idx_q;
    assign o_rd          = rd_q;
    assign o_pc_next     = pcn_q;
    assign o_branch      = br_q;
    assign o_mem_read    = mr_q;
    assign o_mem_write   = mw_q;
    assign o_mem_width   = mwid_q;
    assign o_mem_signed  = msg_q;
    assign o_mem_address = maddr_q;
    assign o_busy        = (state_q != ST_IDLE) || (new_inst && md_op) || (new_inst && i_stall);

endmodule

// File: tb/tb_cpu_execute.sv
// Randomized bench for cpu_execute with a behavioural reference model and per-cycle output comparison.
module tb_cpu_execute;
    import cpu_execute_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_reset, i_src2_imm, i_mem_read, i_mem_write, i_mem_signed, i_stall;
    logic [7:0]  i_tag;
    logic [31:0] i_pc, i_rs1, i_rs2, i_imm;
    logic [4:0]  i_inst_rd, i_op;
    logic [2:0]  i_mem_width;
    logic [7:0]  o_tag;
    logic [4:0]  o_inst_rd;
    logic [31:0] o_rd, o_pc_next, o_mem_address;
    logic        o_branch, o_mem_read, o_mem_write, o_mem_signed, o_busy;
    logic [2:0]  o_mem_width;

    cpu_execute #(.TAG_W(8), .MD_STEPS(32)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_tag(i_tag), .i_pc(i_pc), .i_inst_rd(i_inst_rd),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .i_op(i_op), .i_src2_imm(i_src2_imm),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_width(i_mem_width),
        .i_mem_signed(i_mem_signed), .i_stall(i_stall),
        .o_tag(o_tag), .o_inst_rd(o_inst_rd), .o_rd(o_rd), .o_pc_next(o_pc_next),
        .o_branch(o_branch), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_mem_width(o_mem_width), .o_mem_signed(o_mem_signed),
        .o_mem_address(o_mem_address), .o_busy(o_busy)
    );

    typedef struct packed {
        logic [7:0]  tag;
        logic [4:0]  rd_idx;
        logic [31:0] rd;
        logic [31:0] pc_next;
        logic        branch;
        logic        mr;
        logic        mw;
        logic [2:0]  mwid;
        logic        msg;
        logic [31:0] maddr;
    } out_t;

    int   checks = 0;
    int   errors = 0;
    out_t cur_exp = '0;
    out_t prev_exp = '0;
    logic cur_md = 1'b0;
    bit   chk_en = 1'b0;
    bit   stall_rand = 1'b0;
    logic [7:0] next_tag = 8'd0;
    logic [7:0] old_tag;
    int   cyc;

    // RV32M results straight from the arithmetic definitions.
    function automatic logic [31:0] ref_md(input op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            OP_MUL:    begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            OP_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            OP_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
            OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            OP_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            OP_REM:    begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU:   return (b == 0) ? a : a % b;
            default:   return 32'd0;
        endcase
    endfunction

    function automatic out_t model(input op_e op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] imm, input logic [31:0] pc, input logic s2,
                                   input logic [7:0] tag, input logic [4:0] rdi, input logic mr,
                                   input logic mw, input logic [2:0] wid, input logic sg);
        out_t o;
        logic [31:0] y;
        int sa, sb, sy;
        logic tk;
        y  = s2 ? imm : b;
        sa = a;
        sb = b;
        sy = y;
        tk = 1'b0;
        o  = '0;
        o.tag = tag; o.rd_idx = rdi; o.mr = mr; o.mw = mw; o.mwid = wid; o.msg = sg;
        o.maddr   = a + imm;
        o.pc_next = pc + 32'd4;
        case (op)
            OP_ADD:  o.rd = a + y;
            OP_SUB:  o.rd = a - y;
            OP_SLL:  o.rd = a << y[4:0];
            OP_SLT:  o.rd = (sa < sy) ? 32'd1 : 32'd0;
            OP_SLTU: o.rd = (a < y) ? 32'd1 : 32'd0;
            OP_XOR:  o.rd = a ^ y;
            OP_SRL:  o.rd = a >> y[4:0];
            OP_SRA:  o.rd = sa >>> y[4:0];
            OP_OR:   o.rd = a | y;
            OP_AND:  o.rd = a & y;
            OP_LUI:  o.rd = y;
            OP_BEQ:  tk = (a == b);
            OP_BNE:  tk = (a != b);
            OP_BLT:  tk = (sa < sb);
            OP_BGE:  tk = (sa >= sb);
            OP_BLTU: tk = (a < b);
            OP_BGEU: tk = (a >= b);
            OP_JAL:  begin o.rd = pc + 32'd4; o.pc_next = pc + imm; o.branch = 1'b1; end
            OP_JALR: begin o.rd = pc + 32'd4; o.pc_next = (a + imm) & 32'hFFFF_FFFE; o.branch = 1'b1; end
            OP_LOAD, OP_STORE: o.rd = b;
            default: o.rd = ref_md(op, a, y);
        endcase
        if (tk) begin
            o.pc_next = pc + imm;
            o.branch  = 1'b1;
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic drive(input op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc, input logic s2);
        logic [2:0] wid;
        case ($urandom_range(0, 2))
            0:       wid = 3'd1;
            1:       wid = 3'd2;
            default: wid = 3'd4;
        endcase
        next_tag     = next_tag + 8'd1;
        i_tag        = next_tag;
        i_op         = op;
        i_rs1        = a;
        i_rs2        = b;
        i_imm        = imm;
        i_pc         = pc;
        i_src2_imm   = s2;
        i_inst_rd    = 5'($urandom_range(0, 31));
        i_mem_read   = 1'($urandom_range(0, 1));
        i_mem_write  = 1'($urandom_range(0, 1));
        i_mem_width  = wid;
        i_mem_signed = 1'($urandom_range(0, 1));
        prev_exp     = cur_exp;
        cur_exp      = model(op, a, b, imm, pc, s2, i_tag, i_inst_rd, i_mem_read,
                             i_mem_write, wid, i_mem_signed);
        cur_md       = is_muldiv(op);
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (o_tag != i_tag && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (stall_rand) i_stall = ($urandom_range(0, 3) == 0);
        end
        if (o_tag != i_tag) begin
            checks++;
            errors++;
            $display("FAIL timeout tag got %h want %h", o_tag, i_tag);
        end
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 16));
            default: return $urandom;
        endcase
    endfunction

    // Outputs must equal the new result once the tag flips, and the previous result until then.
    always @(negedge clk) begin
        out_t got, want;
        logic bexp;
        if (chk_en) begin
            got  = {o_tag, o_inst_rd, o_rd, o_pc_next, o_branch, o_mem_read, o_mem_write,
                    o_mem_width, o_mem_signed, o_mem_address};
            want = (o_tag == cur_exp.tag) ? cur_exp : prev_exp;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL outputs t=%0t got %h want %h", $time, got, want);
            end
            bexp = (o_tag != cur_exp.tag) && (cur_md || i_stall);
            checks++;
            if (o_busy !== bexp) begin
                errors++;
                $display("FAIL busy t=%0t got %b want %b", $time, o_busy, bexp);
            end
        end
    end

    initial begin
        i_reset = 1'b0; i_tag = '0; i_pc = '0; i_inst_rd = '0; i_rs1 = '0; i_rs2 = '0;
        i_imm = '0; i_op = '0; i_src2_imm = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
        i_mem_width = '0; i_mem_signed = 1'b0; i_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_reset = 1'b1;
        chk_en  = 1'b1;
        chk("reset_tag", 32'(o_tag), 32'd0);
        chk("reset_rd", o_rd, 32'd0);
        chk("reset_busy", 32'(o_busy), 32'd0);

        drive(OP_ADD, 32'd5, 32'd7, 32'd0, 32'h40, 1'b0);
        wait_done(50, cyc);
        chk("add_lat", cyc, 1);
        chk("add_rd", o_rd, 32'd12);
        chk("add_pcn", o_pc_next, 32'h44);

        drive(OP_BEQ, 32'd3, 32'd3, 32'h20, 32'h100, 1'b0);
        wait_done(50, cyc);
        chk("beq_t_pcn", o_pc_next, 32'h120);
        chk("beq_t_br", 32'(o_branch), 32'd1);
        drive(OP_BEQ, 32'd3, 32'd4, 32'h20, 32'h100, 1'b0);
        wait_done(50, cyc);
        chk("beq_nt_pcn", o_pc_next, 32'h104);
        chk("beq_nt_br", 32'(o_branch), 32'd0);

        drive(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h200, 1'b0);
        wait_done(100, cyc);
        chk("mulhu_lat", cyc, 33);
        chk("mulhu_rd", o_rd, 32'hFFFF_FFFE);
        drive(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h204, 1'b0);
        wait_done(100, cyc);
        chk("mul_rd", o_rd, 32'h0000_0001);
        drive(OP_DIV, 32'd7, 32'd0, 32'd0, 32'h208, 1'b0);
        wait_done(100, cyc);
        chk("div_by0", o_rd, 32'hFFFF_FFFF);
        drive(OP_REM, 32'd7, 32'd0, 32'd0, 32'h20C, 1'b0);
        wait_done(100, cyc);
        chk("rem_by0", o_rd, 32'd7);
        drive(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h210, 1'b0);
        wait_done(100, cyc);
        chk("div_ovf", o_rd, 32'h8000_0000);
        drive(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'h214, 1'b0);
        wait_done(100, cyc);
        chk("rem_neg", o_rd, 32'hFFFF_FFFF);

        // Stall held across the final step: result parks until the stall drops.
        drive(OP_MUL, 32'd6, 32'd7, 32'd0, 32'h300, 1'b0);
        old_tag = prev_exp.tag;
        repeat (32) begin @(posedge clk); #1; end
        i_stall = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        chk("hold_tag", 32'(o_tag), 32'(old_tag));
        chk("hold_busy", 32'(o_busy), 32'd1);
        i_stall = 1'b0;
        @(posedge clk);
        #1;
        chk("release_tag", 32'(o_tag), 32'(cur_exp.tag));
        chk("release_rd", o_rd, 32'd42);

        // Reset pulse at step 10 of a divide, then the same instruction is re-accepted.
        drive(OP_DIV, 32'd100, 32'd7, 32'd0, 32'h400, 1'b0);
        repeat (11) begin @(posedge clk); #1; end
        i_reset = 1'b0;
        @(posedge clk);
        #1;
        i_reset  = 1'b1;
        prev_exp = '0;
        chk("rst_mid_tag", 32'(o_tag), 32'd0);
        chk("rst_mid_rd", o_rd, 32'd0);
        wait_done(100, cyc);
        chk("rst_redo_lat", cyc, 33);
        chk("rst_redo_rd", o_rd, 32'd14);

        for (int n = 0; n < 160; n++) begin
            stall_rand = (n >= 80);
            drive(op_e'(5'($urandom_range(0, 28))), rnd_val(), rnd_val(), rnd_val(),
                  $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
            wait_done(300, cyc);
            if (!stall_rand) chk("rand_lat", cyc, cur_md ? 33 : 1);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        i_stall = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
